// File: rtl/id_ex_pipe_reg_if.sv
// ID -> ID/EX -> EX bundle: decode-side inputs, EX-side registered outputs and the
// stage handshake. "master" drives the decode fields and EX acceptance, "slave" is the register.
interface id_ex_pipe_reg_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned IMM_W  = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned ALUC_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              flush;

  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   read_data1_in;
  logic [XLEN-1:0]   read_data2_in;
  logic [IMM_W-1:0]  imm_val_in;
  logic [RA_W-1:0]   write_reg_in;
  logic [RA_W-1:0]   rs1_in;
  logic [RA_W-1:0]   rs2_in;
  logic [ALUC_W-1:0] alu_control_in;
  logic [1:0]        alu_op_in;
  logic              alusrc_in;
  logic              branch_in;
  logic              memwrite_in;
  logic              memread_in;
  logic              memtoreg_in;
  logic              regwrite_in;

  logic [XLEN-1:0]   pc_out;
  logic [XLEN-1:0]   read_data1_out;
  logic [XLEN-1:0]   read_data2_out;
  logic [XLEN-1:0]   imm_val_out;
  logic [RA_W-1:0]   write_reg_out;
  logic [RA_W-1:0]   rs1_out;
  logic [RA_W-1:0]   rs2_out;
  logic [ALUC_W-1:0] alu_control_out;
  logic [1:0]        alu_op_out;
  logic              alusrc_out;
  logic              branch_out;
  logic              memwrite_out;
  logic              memread_out;
  logic              memtoreg_out;
  logic              regwrite_out;

  logic              hazard_stall;
  logic [31:0]       bubble_cnt;

  modport master (
    output in_valid, out_ready, flush,
    output pc_in, read_data1_in, read_data2_in, imm_val_in,
    output write_reg_in, rs1_in, rs2_in, alu_control_in, alu_op_in,
    output alusrc_in, branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in,
    input  in_ready, out_valid, hazard_stall, bubble_cnt,
    input  pc_out, read_data1_out, read_data2_out, imm_val_out,
    input  write_reg_out, rs1_out, rs2_out, alu_control_out, alu_op_out,
    input  alusrc_out, branch_out, memwrite_out, memread_out, memtoreg_out, regwrite_out
  );

  modport slave (
    input  in_valid, out_ready, flush,
    input  pc_in, read_data1_in, read_data2_in, imm_val_in,
    input  write_reg_in, rs1_in, rs2_in, alu_control_in, alu_op_in,
    input  alusrc_in, branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in,
    output in_ready, out_valid, hazard_stall, bubble_cnt,
    output pc_out, read_data1_out, read_data2_out, imm_val_out,
    output write_reg_out, rs1_out, rs2_out, alu_control_out, alu_op_out,
    output alusrc_out, branch_out, memwrite_out, memread_out, memtoreg_out, regwrite_out
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and EX backpressure.
// Define ID_EX_PERF_CNT_EN to build the bubble counter; otherwise bubble_cnt is tied to 0.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned IMM_W  = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned ALUC_W = 10
) (
  input logic             clk,
  input logic             rst,
  id_ex_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       memread;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] alu_op;
  } ctrl_t;

  logic              valid_q;
  ctrl_t             ctrl_q;
  ctrl_t             ctrl_in;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   rd1_q;
  logic [XLEN-1:0]   rd2_q;
  logic [XLEN-1:0]   imm_q;
  logic [RA_W-1:0]   wr_q;
  logic [RA_W-1:0]   rs1_q;
  logic [RA_W-1:0]   rs2_q;
  logic [ALUC_W-1:0] aluc_q;

  logic              advance;
  logic              hazard;
  logic [XLEN-1:0]   imm_ext;

  always_comb begin
    advance = bus.out_ready | ~valid_q;
    // A write_reg of 0 never matches, so x0 sources cannot stall.
    hazard  = bus.in_valid & valid_q & ctrl_q.memread & (wr_q != '0) &
              ((wr_q == bus.rs1_in) | (wr_q == bus.rs2_in));
    imm_ext = XLEN'($signed(bus.imm_val_in));
    ctrl_in = '{alusrc:   bus.alusrc_in,
                branch:   bus.branch_in,
                memwrite: bus.memwrite_in,
                memread:  bus.memread_in,
                memtoreg: bus.memtoreg_in,
                regwrite: bus.regwrite_in,
                alu_op:   bus.alu_op_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      wr_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      aluc_q  <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (advance) begin
      // Bubble and empty-slot cases both clear control but keep the datapath fields.
      if (hazard || !bus.in_valid) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end else begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl_in;
        pc_q    <= bus.pc_in;
        rd1_q   <= bus.read_data1_in;
        rd2_q   <= bus.read_data2_in;
        imm_q   <= imm_ext;
        wr_q    <= bus.write_reg_in;
        rs1_q   <= bus.rs1_in;
        rs2_q   <= bus.rs2_in;
        aluc_q  <= bus.alu_control_in;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_q <= '0;
    end else if (!bus.flush && advance && hazard) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bus.bubble_cnt = bubble_q;
`else
  assign bus.bubble_cnt = '0;
`endif

  assign bus.in_ready        = advance & ~hazard & ~bus.flush;
  assign bus.hazard_stall    = hazard;
  assign bus.out_valid       = valid_q;
  assign bus.pc_out          = pc_q;
  assign bus.read_data1_out  = rd1_q;
  assign bus.read_data2_out  = rd2_q;
  assign bus.imm_val_out     = imm_q;
  assign bus.write_reg_out   = wr_q;
  assign bus.rs1_out         = rs1_q;
  assign bus.rs2_out         = rs2_q;
  assign bus.alu_control_out = aluc_q;
  assign bus.alu_op_out      = ctrl_q.alu_op;
  assign bus.alusrc_out      = ctrl_q.alusrc;
  assign bus.branch_out      = ctrl_q.branch;
  assign bus.memwrite_out    = ctrl_q.memwrite;
  assign bus.memread_out     = ctrl_q.memread;
  assign bus.memtoreg_out    = ctrl_q.memtoreg;
  assign bus.regwrite_out    = ctrl_q.regwrite;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus a randomized run
// against a cycle-level reference model of the stage.
`timescale 1ns/1ps
module tb_id_ex_pipe_reg;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned IMM_W  = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned ALUC_W = 10;

  typedef struct packed {
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       memread;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] alu_op;
  } tctrl_t;

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [4:0]  wr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [9:0]  aluc;
    tctrl_t      ctrl;
  } stage_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_run  = 0;
  int          n_fail = 0;
  int unsigned bub_exp = 0;
  stage_t      m;

  id_ex_pipe_reg_if #(.XLEN(XLEN), .IMM_W(IMM_W), .RA_W(RA_W), .ALUC_W(ALUC_W)) bus ();

  id_ex_pipe_reg #(.XLEN(XLEN), .IMM_W(IMM_W), .RA_W(RA_W), .ALUC_W(ALUC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bub_ref();
`ifdef ID_EX_PERF_CNT_EN
    return bub_exp;
`else
    return 32'd0;
`endif
  endfunction

  function automatic tctrl_t dut_ctrl();
    return '{alusrc: bus.alusrc_out, branch: bus.branch_out, memwrite: bus.memwrite_out,
             memread: bus.memread_out, memtoreg: bus.memtoreg_out, regwrite: bus.regwrite_out,
             alu_op: bus.alu_op_out};
  endfunction

  task automatic clear_inputs();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
    bus.pc_in = '0; bus.read_data1_in = '0; bus.read_data2_in = '0; bus.imm_val_in = '0;
    bus.write_reg_in = '0; bus.rs1_in = '0; bus.rs2_in = '0; bus.alu_control_in = '0;
    bus.alu_op_in = '0; bus.alusrc_in = 1'b0; bus.branch_in = 1'b0; bus.memwrite_in = 1'b0;
    bus.memread_in = 1'b0; bus.memtoreg_in = 1'b0; bus.regwrite_in = 1'b0;
  endtask

  task automatic put_instr(input logic [63:0] pc, input logic [31:0] imm, input logic [4:0] wr,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                           input logic rw);
    bus.in_valid = 1'b1;
    bus.pc_in = pc; bus.read_data1_in = pc ^ 64'hA5A5_A5A5_A5A5_A5A5; bus.read_data2_in = ~pc;
    bus.imm_val_in = imm; bus.write_reg_in = wr; bus.rs1_in = rs1; bus.rs2_in = rs2;
    bus.alu_control_in = 10'h2A5; bus.alu_op_in = 2'b10; bus.alusrc_in = 1'b1;
    bus.branch_in = 1'b0; bus.memwrite_in = 1'b0; bus.memread_in = mr; bus.memtoreg_in = mr;
    bus.regwrite_in = rw;
  endtask

  task automatic idle();
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
    n_run++; if (bus.pc_out !== 64'd0) begin n_fail++; $display("FAIL reset_pc_out got=%0h exp=0", bus.pc_out); end
    n_run++; if (dut_ctrl() !== 8'd0) begin n_fail++; $display("FAIL reset_ctrl got=%0h exp=0", dut_ctrl()); end
    n_run++; if (bus.bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_bubble_cnt got=%0d exp=0", bus.bubble_cnt); end
    @(negedge clk); rst = 1'b1; bub_exp = 0;
    #1;
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", bus.in_ready); end
  endtask

  task automatic test_sign_ext();
    @(negedge clk); put_instr(64'h100, 32'hFFFF_FFF0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_run++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sext_out_valid got=%0h exp=1", bus.out_valid); end
    n_run++; if (bus.pc_out !== 64'h100) begin n_fail++; $display("FAIL sext_pc_out got=%0h exp=100", bus.pc_out); end
    n_run++; if (bus.imm_val_out !== 64'hFFFF_FFFF_FFFF_FFF0) begin n_fail++; $display("FAIL sext_imm_neg got=%0h exp=fffffffffffffff0", bus.imm_val_out); end
    n_run++; if (bus.write_reg_out !== 5'd3) begin n_fail++; $display("FAIL sext_write_reg got=%0d exp=3", bus.write_reg_out); end
    @(negedge clk); put_instr(64'h104, 32'h7FFF_FFF0, 5'd4, 5'd1, 5'd2, 1'b0, 1'b1);
    @(posedge clk); #1;
    n_run++; if (bus.imm_val_out !== 64'h0000_0000_7FFF_FFF0) begin n_fail++; $display("FAIL sext_imm_pos got=%0h exp=7ffffff0", bus.imm_val_out); end
    n_run++; if (bus.pc_out !== 64'h104) begin n_fail++; $display("FAIL b2b_pc_out got=%0h exp=104", bus.pc_out); end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_out_valid got=%0h exp=0", bus.out_valid); end
    n_run++; if (dut_ctrl() !== 8'd0) begin n_fail++; $display("FAIL empty_ctrl got=%0h exp=0", dut_ctrl()); end
  endtask

  task automatic test_load_use();
    idle();
    @(negedge clk); put_instr(64'h200, 32'd8, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_run++; if (bus.memread_out !== 1'b1) begin n_fail++; $display("FAIL lu_load_memread got=%0h exp=1", bus.memread_out); end
    @(negedge clk); put_instr(64'h204, 32'd4, 5'd7, 5'd5, 5'd3, 1'b0, 1'b1);
    #1;
    n_run++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_hazard_stall got=%0h exp=1", bus.hazard_stall); end
    n_run++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_in_ready got=%0h exp=0", bus.in_ready); end
    @(posedge clk); #1; bub_exp++;
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid got=%0h exp=0", bus.out_valid); end
    n_run++; if (bus.memread_out !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_memread got=%0h exp=0", bus.memread_out); end
    n_run++; if (bus.pc_out !== 64'h200) begin n_fail++; $display("FAIL lu_bubble_pc_hold got=%0h exp=200", bus.pc_out); end
    n_run++; if (bus.bubble_cnt !== bub_ref()) begin n_fail++; $display("FAIL lu_bubble_cnt got=%0d exp=%0d", bus.bubble_cnt, bub_ref()); end
    @(negedge clk); #1;
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_resolve_in_ready got=%0h exp=1", bus.in_ready); end
    @(posedge clk); #1;
    n_run++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 64'h204) begin n_fail++; $display("FAIL lu_capture got=%0h/%0h exp=1/204", bus.out_valid, bus.pc_out); end
    n_run++; if (bus.write_reg_out !== 5'd7) begin n_fail++; $display("FAIL lu_capture_wr got=%0d exp=7", bus.write_reg_out); end
  endtask

  task automatic test_zero_reg();
    idle();
    @(negedge clk); put_instr(64'h600, 32'd0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); put_instr(64'h604, 32'd0, 5'd9, 5'd4, 5'd0, 1'b0, 1'b1);
    #1;
    n_run++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL zr_hazard_stall got=%0h exp=0", bus.hazard_stall); end
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL zr_in_ready got=%0h exp=1", bus.in_ready); end
    @(posedge clk); #1;
    n_run++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 64'h604) begin n_fail++; $display("FAIL zr_capture got=%0h/%0h exp=1/604", bus.out_valid, bus.pc_out); end
    n_run++; if (bus.bubble_cnt !== bub_ref()) begin n_fail++; $display("FAIL zr_bubble_cnt got=%0d exp=%0d", bus.bubble_cnt, bub_ref()); end
  endtask

  task automatic test_backpressure();
    idle();
    @(negedge clk); put_instr(64'h300, 32'h11, 5'd6, 5'd1, 5'd2, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); put_instr(64'h304, 32'h22, 5'd8, 5'd6, 5'd6, 1'b0, 1'b1); bus.out_ready = 1'b0;
      #1;
      n_run++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, bus.in_ready); end
      @(posedge clk); #1;
      n_run++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 64'h300 || bus.imm_val_out !== 64'h11) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=%0h/%0h/%0h exp=1/300/11", i, bus.out_valid, bus.pc_out, bus.imm_val_out);
      end
    end
    @(negedge clk); bus.out_ready = 1'b1;
    #1;
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%0h exp=1", bus.in_ready); end
    @(posedge clk); #1;
    n_run++; if (bus.pc_out !== 64'h304) begin n_fail++; $display("FAIL bp_release_pc got=%0h exp=304", bus.pc_out); end
  endtask

  task automatic test_flush();
    idle();
    @(negedge clk); put_instr(64'h500, 32'd0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); put_instr(64'h504, 32'd0, 5'd10, 5'd5, 5'd2, 1'b0, 1'b1); bus.flush = 1'b1;
    #1;
    n_run++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_in_ready got=%0h exp=0", bus.in_ready); end
    n_run++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL fl_hazard_stall got=%0h exp=1", bus.hazard_stall); end
    @(posedge clk); #1;
    n_run++; if (bus.out_valid !== 1'b0 || bus.regwrite_out !== 1'b0) begin n_fail++; $display("FAIL fl_squash got=%0h/%0h exp=0/0", bus.out_valid, bus.regwrite_out); end
    n_run++; if (dut_ctrl() !== 8'd0) begin n_fail++; $display("FAIL fl_ctrl got=%0h exp=0", dut_ctrl()); end
    n_run++; if (bus.bubble_cnt !== bub_ref()) begin n_fail++; $display("FAIL fl_bubble_cnt got=%0d exp=%0d", bus.bubble_cnt, bub_ref()); end
    @(negedge clk); bus.flush = 1'b0;
    @(posedge clk); #1;
    n_run++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 64'h504) begin n_fail++; $display("FAIL fl_after got=%0h/%0h exp=1/504", bus.out_valid, bus.pc_out); end
  endtask

  task automatic test_async_reset();
    idle();
    @(negedge clk); put_instr(64'h400, 32'hFFFF_0000, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); put_instr(64'h404, 32'd12, 5'd6, 5'd5, 5'd0, 1'b0, 1'b1);
    #1;
    n_run++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL ar_stall got=%0h exp=1", bus.hazard_stall); end
    #1; rst = 1'b0;
    #1;
    n_run++; if (bus.out_valid !== 1'b0 || bus.pc_out !== 64'd0 || bus.imm_val_out !== 64'd0) begin
      n_fail++; $display("FAIL ar_clear got=%0h/%0h/%0h exp=0/0/0", bus.out_valid, bus.pc_out, bus.imm_val_out);
    end
    n_run++; if (bus.write_reg_out !== 5'd0 || dut_ctrl() !== 8'd0) begin n_fail++; $display("FAIL ar_clear_ctrl got=%0h/%0h exp=0/0", bus.write_reg_out, dut_ctrl()); end
    n_run++; if (bus.bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_bubble_cnt got=%0d exp=0", bus.bubble_cnt); end
    bub_exp = 0;
    @(negedge clk); rst = 1'b1;
    #1;
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_release_in_ready got=%0h exp=1", bus.in_ready); end
    @(posedge clk); #1;
    n_run++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 64'h404) begin n_fail++; $display("FAIL ar_release_capture got=%0h/%0h exp=1/404", bus.out_valid, bus.pc_out); end
  endtask

  task automatic test_random();
    logic hz, adv, rdy;
    @(negedge clk); clear_inputs(); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    m = '{valid: 1'b0, pc: '0, rd1: '0, rd2: '0, imm: '0, wr: '0, rs1: '0, rs2: '0, aluc: '0, ctrl: '0};
    bub_exp = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.in_valid       = ($urandom_range(0, 3) != 0);
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      bus.flush          = ($urandom_range(0, 11) == 0);
      bus.pc_in          = {$urandom, $urandom};
      bus.read_data1_in  = {$urandom, $urandom};
      bus.read_data2_in  = {$urandom, $urandom};
      bus.imm_val_in     = $urandom;
      bus.write_reg_in   = 5'($urandom_range(0, 7));
      bus.rs1_in         = 5'($urandom_range(0, 7));
      bus.rs2_in         = 5'($urandom_range(0, 7));
      bus.alu_control_in = 10'($urandom);
      bus.alu_op_in      = 2'($urandom);
      bus.alusrc_in      = 1'($urandom);
      bus.branch_in      = 1'($urandom);
      bus.memwrite_in    = 1'($urandom);
      bus.memread_in     = ($urandom_range(0, 4) < 2);
      bus.memtoreg_in    = 1'($urandom);
      bus.regwrite_in    = 1'($urandom);
      #1;
      hz  = bus.in_valid && m.valid && m.ctrl.memread && (m.wr != 0) &&
            (m.wr == bus.rs1_in || m.wr == bus.rs2_in);
      adv = bus.out_ready || !m.valid;
      rdy = adv && !hz && !bus.flush;
      n_run++; if (bus.hazard_stall !== hz) begin n_fail++; $display("FAIL rnd_hazard[%0d] got=%0h exp=%0h", c, bus.hazard_stall, hz); end
      n_run++; if (bus.in_ready !== rdy) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got=%0h exp=%0h", c, bus.in_ready, rdy); end
      if (bus.flush) begin
        m.valid = 1'b0; m.ctrl = '0;
      end else if (adv && hz) begin
        m.valid = 1'b0; m.ctrl = '0; bub_exp++;
      end else if (adv && bus.in_valid) begin
        m.valid = 1'b1; m.pc = bus.pc_in; m.rd1 = bus.read_data1_in; m.rd2 = bus.read_data2_in;
        m.imm = {{32{bus.imm_val_in[31]}}, bus.imm_val_in};
        m.wr = bus.write_reg_in; m.rs1 = bus.rs1_in; m.rs2 = bus.rs2_in; m.aluc = bus.alu_control_in;
        m.ctrl = '{alusrc: bus.alusrc_in, branch: bus.branch_in, memwrite: bus.memwrite_in,
                   memread: bus.memread_in, memtoreg: bus.memtoreg_in, regwrite: bus.regwrite_in,
                   alu_op: bus.alu_op_in};
      end else if (adv) begin
        m.valid = 1'b0; m.ctrl = '0;
      end
      @(posedge clk); #1;
      n_run++; if (bus.out_valid !== m.valid) begin n_fail++; $display("FAIL rnd_out_valid[%0d] got=%0h exp=%0h", c, bus.out_valid, m.valid); end
      n_run++; if (dut_ctrl() !== m.ctrl) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got=%0h exp=%0h", c, dut_ctrl(), m.ctrl); end
      n_run++; if (bus.bubble_cnt !== bub_ref()) begin n_fail++; $display("FAIL rnd_bubble_cnt[%0d] got=%0d exp=%0d", c, bus.bubble_cnt, bub_ref()); end
      if (m.valid) begin
        n_run++; if (bus.pc_out !== m.pc || bus.read_data1_out !== m.rd1 || bus.read_data2_out !== m.rd2) begin
          n_fail++; $display("FAIL rnd_data[%0d] got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, bus.pc_out, bus.read_data1_out, bus.read_data2_out, m.pc, m.rd1, m.rd2);
        end
        n_run++; if (bus.imm_val_out !== m.imm) begin n_fail++; $display("FAIL rnd_imm[%0d] got=%0h exp=%0h", c, bus.imm_val_out, m.imm); end
        n_run++; if ({bus.write_reg_out, bus.rs1_out, bus.rs2_out, bus.alu_control_out} !== {m.wr, m.rs1, m.rs2, m.aluc}) begin
          n_fail++; $display("FAIL rnd_regs[%0d] got=%0h exp=%0h", c, {bus.write_reg_out, bus.rs1_out, bus.rs2_out, bus.alu_control_out}, {m.wr, m.rs1, m.rs2, m.aluc});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sign_ext();
    test_load_use();
    test_zero_reg();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
